// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one half-adder-built full adder is time-shared
// over WIDTH clocks to add two WIDTH-bit operands LSB-first.

module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   logic s0, c0, c1;

   half_adder u_ha0 (.x(x),  .y(y),  .s(s0), .c(c0));
   half_adder u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

   assign co = c0 | c1;
endmodule

// state | meaning
// IDLE  | waiting for start; sum/cout hold the last completed result
// RUN   | one result bit per clock; terminates when the counter hits WIDTH-1
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, r, r_nx;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s, fa_c;
   logic             last, accept;

   full_adder u_fa (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_c)
   );

   // New bit enters at the MSB so the LSB-first result ends up aligned.
   generate
      if (WIDTH == 1) begin : g_r1
         assign r_nx = fa_s;
      end else begin : g_rn
         assign r_nx = {fa_s, r[WIDTH-1:1]};
      end
   endgenerate

   assign last = (cnt == CW'(WIDTH - 1));
   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            if (last) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         r     <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (state == RUN) begin
            r     <= r_nx;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            if (last) begin
               sum  <= r_nx;
               cout <= fa_c;
               done <= 1'b1;
            end
         end
      end
   end
endmodule
